// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared shift opcodes, widths and request record
// Purpose: common types for the shift issue stage and its shift core.
// Contents: DATA_W/AMT_W widths, shift_op_e opcode enum, shift_req_t record.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_RSV = 2'b11
  } shift_op_e;

  // The tag width is a parameter of the issue unit, so the tag is wrapped
  // around this record there rather than carried inside it.
  typedef struct packed {
    shift_op_e           op;
    logic [DATA_W-1:0]   data;
    logic [AMT_W-1:0]    amt;
  } shift_req_t;

endpackage

// File: rtl/shift_core.sv
// rtl/shift_core.sv - combinational 32-bit log-stage shifter
// Purpose: SLL / SRL / SRA through 16/8/4/2/1 stages; reserved op passes through.
// Ports:
//   i_op      opcode (shift_op_e)
//   i_data    operand
//   i_amt     shift amount 0..31
//   o_data    shifted result
//   o_illegal high for the reserved opcode
module shift_core
  import alu_pkg::*;
(
  input  shift_op_e         i_op,
  input  logic [DATA_W-1:0] i_data,
  input  logic [AMT_W-1:0]  i_amt,
  output logic [DATA_W-1:0] o_data,
  output logic              o_illegal
);

  logic w_fill;
  logic [DATA_W-1:0] w_stage;

  always_comb begin
    w_fill  = (i_op == SHIFT_SRA) && i_data[DATA_W-1];
    w_stage = i_data;
    for (int k = AMT_W - 1; k >= 0; k--) begin
      if (i_amt[k]) begin
        case (i_op)
          SHIFT_SLL: w_stage = w_stage << (1 << k);
          // Right shift with ones fill is the complement of a zero-fill
          // shift of the complement.
          SHIFT_SRL,
          SHIFT_SRA: w_stage = w_fill ? ~((~w_stage) >> (1 << k))
                                      : (w_stage >> (1 << k));
          default:   w_stage = w_stage;
        endcase
      end
    end
    o_data    = w_stage;
    o_illegal = (i_op == SHIFT_RSV);
  end

endmodule

// File: rtl/shift_issue_unit.sv
// rtl/shift_issue_unit.sv - request FIFO feeding shift core and result register
// Purpose: buffers shift requests, shifts the head entry and holds the result
//   in a registered output stage with its own valid/ready handshake.
// Ports:
//   clk, rst_n (async active-low), flush (sync clear)
//   in_valid/in_ready/in_op/in_data/in_amt/in_tag   request side
//   out_valid/out_ready/out_data/out_tag/out_illegal result side
//   count                                           FIFO occupancy
module shift_issue_unit
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_op,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [AMT_W-1:0]           in_amt,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    shift_req_t       req;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [TAG_W-1:0]  r_out_tag;
  logic              r_out_illegal;

  entry_t            w_in;
  entry_t            w_head;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_core_data;
  logic              w_core_illegal;

  always_comb begin
    w_in.req.op   = shift_op_e'(in_op);
    w_in.req.data = in_data;
    w_in.req.amt  = in_amt;
    w_in.tag      = in_tag;
  end

  // in_ready looks only at the registered count, so out_ready never reaches it.
  assign in_ready = (r_count < DEPTH_C);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_count != '0) && (!r_out_valid || out_ready);
  assign w_head   = r_mem[r_head];

  shift_core u_shift_core (
    .i_op      (w_head.req.op),
    .i_data    (w_head.req.data),
    .i_amt     (w_head.req.amt),
    .o_data    (w_core_data),
    .o_illegal (w_core_illegal)
  );

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_tail] <= w_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_tag     <= '0;
      r_out_illegal <= 1'b0;
    end else if (flush) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head        <= r_head + 1'b1;
        r_out_valid   <= 1'b1;
        r_out_data    <= w_core_data;
        r_out_tag     <= w_head.tag;
        r_out_illegal <= w_core_illegal;
      end else if (out_ready) begin
        // Consumer took the result and nothing is queued behind it.
        r_out_valid <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_tag     = r_out_tag;
  assign out_illegal = r_out_illegal;
  assign count       = r_count;

endmodule

// File: tb/tb_shift_issue_unit.sv
// tb/tb_shift_issue_unit.sv - self-checking bench for shift_issue_unit
module tb_shift_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_data = '0;
  logic [4:0]  in_amt = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_illegal;
  logic [2:0]  count;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    logic        il;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  shift_issue_unit #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data(in_data), .in_amt(in_amt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_illegal(out_illegal), .count(count)
  );

  function automatic logic [31:0] ref_shift(logic [1:0] op, logic [31:0] d, logic [4:0] a);
    case (op)
      2'b00:   return d << a;
      2'b01:   return d >> a;
      2'b10:   return 32'($signed(d) >>> a);
      default: return d;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Scoreboard at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_tag", 32'(out_tag), 32'(e.t));
          chk("sb_illegal", 32'(out_illegal), 32'(e.il));
        end
      end
      if (in_valid && in_ready) begin
        e.d  = ref_shift(in_op, in_data, in_amt);
        e.t  = in_tag;
        e.il = (in_op == 2'b11);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(logic [1:0] op, logic [31:0] d, logic [4:0] a, logic [3:0] t);
    in_op = op; in_data = d; in_amt = a; in_tag = t;
  endtask

  task automatic do_one(string name, logic [1:0] op, logic [31:0] d, logic [4:0] a,
                        logic [3:0] t, logic [31:0] exp_d, logic exp_il);
    out_ready = 1'b1;
    set_req(op, d, a, t);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({name, "_lat_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_lat_count"}, 32'(count), 32'd1);
    tick();
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_data"}, out_data, exp_d);
    chk({name, "_tag"}, 32'(out_tag), 32'(t));
    chk({name, "_illegal"}, 32'(out_illegal), 32'(exp_il));
    tick();
    chk({name, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] held;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_illegal", 32'(out_illegal), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single operations and arithmetic fill
    do_one("sll31", 2'b00, 32'h0000_0001, 5'd31, 4'd3, 32'h8000_0000, 1'b0);
    do_one("sra4", 2'b10, 32'h8000_00F0, 5'd4, 4'd5, 32'hF800_000F, 1'b0);
    do_one("srl4", 2'b01, 32'h8000_00F0, 5'd4, 4'd6, 32'h0800_000F, 1'b0);
    do_one("sll0", 2'b00, 32'hDEAD_BEEF, 5'd0, 4'd7, 32'hDEAD_BEEF, 1'b0);
    do_one("srl0", 2'b01, 32'hDEAD_BEEF, 5'd0, 4'd8, 32'hDEAD_BEEF, 1'b0);
    do_one("sra0", 2'b10, 32'hDEAD_BEEF, 5'd0, 4'd9, 32'hDEAD_BEEF, 1'b0);
    do_one("rsv0", 2'b11, 32'hDEAD_BEEF, 5'd0, 4'd10, 32'hDEAD_BEEF, 1'b1);
    do_one("rsv7", 2'b11, 32'h1234_5678, 5'd7, 4'd11, 32'h1234_5678, 1'b1);

    // Backpressure and full
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(2'b00, 32'h0101_0101 * i, 5'(i), 4'(i));
      in_valid = 1'b1;
      tick();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_tag", 32'(out_tag), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    held = out_data;
    set_req(2'b01, 32'hFFFF_FFFF, 5'd1, 4'd5);
    tick();
    in_valid = 1'b0;
    chk("full_blocked_count", 32'(count), 32'd4);
    tick();
    chk("stall_data", out_data, held);
    chk("stall_tag", 32'(out_tag), 32'd0);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("order_tag", 32'(out_tag), 32'(i));
      chk("order_valid", 32'(out_valid), 32'd1);
    end
    tick();
    chk("order_drain", 32'(out_valid), 32'd0);

    // Simultaneous push/pop across pointer wrap
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      set_req(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 4'(i));
      in_valid = 1'b1;
      if (i == 3) out_ready = 1'b1;
      tick();
      if (i >= 3) chk("wrap_count", 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("wrap_drain_valid", 32'(out_valid), 32'd0);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      set_req(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      chk("rand_occupancy", 32'(count) + 32'(out_valid), 32'(sb.size()));
      chk("rand_in_ready", 32'(in_ready), 32'(sb.size() - 32'(out_valid) < 4));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);

    // Flush with count=3 and a stalled result
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(2'b01, $urandom, 5'd3, 4'(i));
      in_valid = 1'b1;
      tick();
    end
    chk("pre_flush_count", 32'(count), 32'd3);
    chk("pre_flush_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    set_req(2'b00, 32'hAAAA_5555, 5'd1, 4'd12);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("flush_ignored_push", 32'(count), 32'd0);
    chk("flush_ignored_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset between clock edges
    for (int i = 0; i < 3; i++) begin
      set_req(2'b00, 32'hFFFF_FFFF, 5'd4, 4'(i + 1));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_tag", 32'(out_tag), 32'd0);
    chk("arst_illegal", 32'(out_illegal), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    do_one("post_rst", 2'b10, 32'h4000_0000, 5'd30, 4'd2, 32'h0000_0001, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
